// File: rtl/period_meter.sv
// period_meter: measures the period of an asynchronous square wave
// in hclkin cycles, rejects short glitches and flags loss of feedback.
//
// Ports:
//   hclkin       in   clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   sig_in       in   asynchronous feedback signal
//   period_out   out  last measured period (CNT_W bits)
//   period_valid out  one-cycle pulse when period_out updates
//   locked       out  high while valid periods are being measured
//   glitch       out  one-cycle pulse on a rejected (too short) edge
//   lost         out  one-cycle pulse when no edge arrives in time
module period_meter #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             glitch,
    output logic             lost
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic s1_q, s2_q, s3_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             glitch_q, glitch_d;
    logic             lost_q, lost_d;

    logic             rise;
    logic             accept;
    logic             reject;
    logic             expire;
    logic [CNT_W-1:0] cnt_inc;

    assign rise    = s2_q & ~s3_q;
    assign accept  = rise && (cnt_q >= MIN_C);
    assign reject  = rise && !accept;
    // An accepted edge on the timeout cycle wins; lost stays quiet.
    assign expire  = (cnt_q == TO_C) && !accept;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        glitch_d = 1'b0;
        lost_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = ONE_C;
                    state_d = ARMED;
                end
            end
            ARMED, LOCKED: begin
                cnt_d = cnt_inc;
                if (accept) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = ONE_C;
                    state_d  = LOCKED;
                end else if (expire) begin
                    lost_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (reject) begin
                    glitch_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge hclkin) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            glitch_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            glitch_q <= glitch_d;
            lost_q   <= lost_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign glitch       = glitch_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized and directed bench for period_meter
// against a timestamp-based reference model.
module tb_period_meter;

    localparam int CNT_W = 16;
    localparam int MIN   = 8;
    localparam int TO    = 500;

    logic             hclkin = 1'b0;
    logic             reset  = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             glitch;
    logic             lost;

    period_meter #(
        .CNT_W(CNT_W),
        .MIN_PERIOD(MIN),
        .TIMEOUT(TO)
    ) dut (
        .hclkin(hclkin),
        .reset(reset),
        .sig_in(sig_in),
        .period_out(period_out),
        .period_valid(period_valid),
        .locked(locked),
        .glitch(glitch),
        .lost(lost)
    );

    always #5 hclkin = ~hclkin;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    // Reference model: absolute drive-cycle timestamps of rising edges.
    bit          m_armed = 0;
    bit          m_locked = 0;
    bit          m_prev = 0;
    int          m_last = 0;
    int          n = 0;
    logic [15:0] m_pout = '0;

    // Outputs appear 3 sampling edges after the drive that caused them.
    logic [19:0] expq[$];
    bit          stim[$];

    task automatic model_step(input bit v, output logic [19:0] e);
        bit rise, pv, gl, ls;
        pv = 0;
        gl = 0;
        ls = 0;
        rise = v && !m_prev;
        m_prev = v;
        if (m_armed) begin
            if (rise && (n - m_last) >= MIN) begin
                m_pout = 16'(n - m_last);
                pv = 1;
                m_locked = 1;
                m_last = n;
            end else begin
                gl = rise;
                if (n - m_last == TO) begin
                    ls = 1;
                    m_armed = 0;
                    m_locked = 0;
                end
            end
        end else if (rise) begin
            m_armed = 1;
            m_last = n;
        end
        e = {m_pout, pv, m_locked, gl, ls};
        n++;
    endtask

    task automatic tick(input bit v, output logic [19:0] o,
                        output logic [19:0] e, output bit h);
        logic [19:0] ne;
        @(negedge hclkin);
        o = {period_out, period_valid, locked, glitch, lost};
        h = (expq.size() == 3);
        e = h ? expq.pop_front() : '0;
        sig_in = v;
        model_step(v, ne);
        expq.push_back(ne);
        tcyc++;
    endtask

    task automatic do_reset(output logic [19:0] o);
        logic [19:0] ne;
        @(negedge hclkin);
        reset = 1'b1;
        sig_in = 1'b0;
        expq.delete();
        @(negedge hclkin);
        o = {period_out, period_valid, locked, glitch, lost};
        reset = 1'b0;
        sig_in = 1'b0;
        m_armed = 0;
        m_locked = 0;
        m_prev = 0;
        m_pout = '0;
        model_step(1'b0, ne);
        expq.push_back(ne);
        tcyc += 2;
    endtask

    task automatic add(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) stim.push_back(1'b1);
            for (int i = 0; i < lo; i++) stim.push_back(1'b0);
        end
    endtask

    task automatic test_reset();
        logic [19:0] o, e;
        bit h;
        do_reset(o);
        checks++;
        if (o[19:4] !== 16'd0) begin
            errors++;
            $display("FAIL reset_period got %h exp 0", o[19:4]);
        end
        checks++;
        if (o[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", o[3:0]);
        end
        stim.delete();
        add(0, 20, 1);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_idle cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
        end
    endtask

    task automatic test_steady();
        logic [19:0] o, e;
        bit h, first, prev_lk;
        int npv, nbad;
        first = 1;
        prev_lk = 0;
        npv = 0;
        nbad = 0;
        stim.delete();
        add(50, 50, 6);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL steady cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[3] === 1'b1) begin
                npv++;
                if (first) begin
                    first = 0;
                    checks++;
                    if (!(o[2] === 1'b1 && prev_lk === 1'b0)) begin
                        errors++;
                        $display("FAIL lock_with_valid got lk %b prev %b exp 1 0",
                                 o[2], prev_lk);
                    end
                end
                checks++;
                if (o[19:4] !== 16'd100) begin
                    errors++;
                    $display("FAIL steady_period got %0d exp 100", o[19:4]);
                end
            end
            if (o[1] === 1'b1 || o[0] === 1'b1) nbad++;
            prev_lk = o[2];
        end
        checks++;
        if (npv != 5) begin
            errors++;
            $display("FAIL steady_valid_count got %0d exp 5", npv);
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL steady_no_events got %0d exp 0", nbad);
        end
    endtask

    task automatic test_switch();
        logic [19:0] o, e;
        bit h;
        int npv, drops;
        int want[8] = '{100, 100, 100, 63, 37, 37, 37, 37};
        npv = 0;
        drops = 0;
        stim.delete();
        add(50, 50, 2);
        add(50, 13, 1);
        add(18, 19, 5);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL switch cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[2] !== 1'b1) drops++;
            if (o[3] === 1'b1) begin
                if (npv < 8) begin
                    checks++;
                    if (o[19:4] !== 16'(want[npv])) begin
                        errors++;
                        $display("FAIL switch_period #%0d got %0d exp %0d",
                                 npv, o[19:4], want[npv]);
                    end
                end
                npv++;
            end
        end
        checks++;
        if (npv != 8) begin
            errors++;
            $display("FAIL switch_valid_count got %0d exp 8", npv);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL switch_locked_drop got %0d exp 0", drops);
        end
    endtask

    task automatic test_glitch();
        logic [19:0] o, e;
        bit h;
        int ngl, npv;
        logic [15:0] last_p;
        ngl = 0;
        npv = 0;
        last_p = '0;
        stim.delete();
        add(2, 98, 2);
        add(2, 2, 1);
        add(2, 94, 1);
        add(2, 98, 1);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL glitch cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[1] === 1'b1) begin
                ngl++;
                checks++;
                if (o[19:4] !== 16'd100) begin
                    errors++;
                    $display("FAIL glitch_hold_period got %0d exp 100",
                             o[19:4]);
                end
            end
            if (o[3] === 1'b1) begin
                npv++;
                last_p = o[19:4];
            end
        end
        checks++;
        if (ngl != 1) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 1", ngl);
        end
        checks++;
        if (npv != 4 || last_p !== 16'd100) begin
            errors++;
            $display("FAIL glitch_next_edge got n %0d p %0d exp n 4 p 100",
                     npv, last_p);
        end
    endtask

    task automatic test_timeout();
        logic [19:0] o, e;
        bit h, prev_lk;
        int last_pv, nlost, npv_after;
        prev_lk = 1;
        last_pv = 0;
        nlost = 0;
        npv_after = 0;
        stim.delete();
        add(2, 98, 2);
        add(0, 600, 1);
        add(2, 98, 3);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL timeout cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[3] === 1'b1) begin
                last_pv = tcyc;
                if (nlost > 0) npv_after++;
            end
            if (o[0] === 1'b1) begin
                nlost++;
                checks++;
                if (tcyc - last_pv != TO) begin
                    errors++;
                    $display("FAIL lost_delay got %0d exp %0d",
                             tcyc - last_pv, TO);
                end
                checks++;
                if (!(o[2] === 1'b0 && prev_lk === 1'b1)) begin
                    errors++;
                    $display("FAIL lost_unlock got lk %b prev %b exp 0 1",
                             o[2], prev_lk);
                end
                checks++;
                if (o[19:4] !== 16'd100) begin
                    errors++;
                    $display("FAIL lost_hold_period got %0d exp 100",
                             o[19:4]);
                end
            end
            prev_lk = o[2];
        end
        checks++;
        if (nlost != 1 || npv_after != 2 || o[2] !== 1'b1) begin
            errors++;
            $display("FAIL relock got lost %0d pv %0d lk %b exp 1 2 1",
                     nlost, npv_after, o[2]);
        end
    endtask

    task automatic test_coincide();
        logic [19:0] o, e;
        bit h;
        int n500, nlost;
        n500 = 0;
        nlost = 0;
        stim.delete();
        add(1, 499, 3);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL coincide cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[3] === 1'b1 && o[19:4] === 16'(TO)) n500++;
            if (o[0] === 1'b1) nlost++;
        end
        checks++;
        if (n500 != 2 || nlost != 0) begin
            errors++;
            $display("FAIL coincide_edge got pv500 %0d lost %0d exp 2 0",
                     n500, nlost);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] o, e;
        bit h;
        int npv, rcyc, first_at;
        logic [15:0] first_p;
        npv = 0;
        first_at = -1;
        first_p = '0;
        stim.delete();
        add(50, 50, 2);
        add(50, 20, 1);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL pre_reset cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
        end
        checks++;
        if (o[2] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_locked got %b exp 1", o[2]);
        end
        do_reset(o);
        rcyc = tcyc;
        checks++;
        if (o !== 20'd0) begin
            errors++;
            $display("FAIL midrun_reset got %h exp 0", o);
        end
        stim.delete();
        add(0, 28, 1);
        add(50, 50, 3);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL post_reset cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
            if (o[3] === 1'b1) begin
                if (npv == 0) begin
                    first_at = tcyc - rcyc;
                    first_p = o[19:4];
                end
                npv++;
            end
        end
        checks++;
        if (npv != 2 || first_p !== 16'd100 || first_at < 100) begin
            errors++;
            $display("FAIL post_reset_first got n %0d p %0d at %0d exp 2 100 >=100",
                     npv, first_p, first_at);
        end
    endtask

    task automatic test_random();
        logic [19:0] o, e;
        bit h;
        int lo;
        stim.delete();
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0)
                lo = 480 + $urandom_range(0, 80);
            else
                lo = $urandom_range(1, 220);
            add($urandom_range(1, 12), lo, 1);
        end
        add(0, 10, 1);
        while (stim.size() > 0) begin
            tick(stim.pop_front(), o, e, h);
            if (h) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random cyc %0d got %h exp %h",
                             tcyc, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_switch();
        test_glitch();
        test_timeout();
        test_coincide();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
